delay_sched_rr: RTL
===================

// Module: delay_sched_rr
// PURPOSE
//  Shares one millisecond delay engine (prescaler + down-counter) between NREQ requesters
//  (servo sequencer, camera settle, motor-step FSMs) in the robot-vision design.
//  Round-robin arbiter grants one requester at a time, latches its delay, counts it, pulses done.
//  Replaces per-FSM free-running delay counters with one scheduled resource.
// PARAMETERS
//  NREQ      4      number of requesters, >=2
//  DW        16     width of per-requester delay request, in ms
//  TICK_DIV  50000  clk cycles per ms tick (50 MHz clk); sims use 4
// PORTS
//  clk        in   1        system clock
//  rstn       in   1        reset, asynchronous, active-low
//  req        in   NREQ     level request per requester; held high until done or abort
//  req_ms     in   NREQ*DW  delay per requester, slice i = [i*DW +: DW]; sampled at grant only
//  grant      out  NREQ     one-hot, requester currently owning the engine
//  done       out  NREQ     one-cycle pulse, delay of requester i completed
//  busy       out  1        engine not IDLE
//  cur_id     out  clog2(NREQ)  index of current/last granted requester
//  remain_ms  out  DW       ms remaining for current grant; 0 when idle
// BEHAVIOUR
//  Reset: grant=0, done=0, busy=0, cur_id=0, remain_ms=0, rr pointer=0, served mask=0, state IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE; abort path RUN -> IDLE.
//  IDLE, cycle T0: eligible = req & ~served. If eligible!=0, pick first set bit searching from
//   rr pointer upward with wrap. Register grant[i]=1, cur_id=i, remain_ms=req_ms[i], prescaler=0.
//   RUN from T1.
//  RUN: if remain_ms==0 -> DONE. Else prescaler counts 0..TICK_DIV-1, wraps.
//   On wrap, remain_ms decrements.
//  DONE: done[i]=1 and grant=0 for exactly one cycle. served[i] set. rr pointer=(i+1) mod NREQ.
//   IDLE next cycle.
//  Latency: done[i] high in cycle T0+2+N*TICK_DIV, N=latched req_ms. N=0 gives done at T0+2.
//   grant[i] high T1..done-1.
//  served[i] clears in any cycle req[i]==0. Re-request needs req low >=1 cycle; no double service.
//  Abort: req[cur_id] low in RUN -> next cycle IDLE, grant=0, remain_ms=0, no done pulse.
//   Abort wins over cnt==0 in the same cycle. rr pointer advances as for DONE.
//  req_ms changes after grant are ignored. Requests arriving during RUN/DONE wait.
//  Simultaneous requests in IDLE: round-robin order; worst-case wait (NREQ-1) services.
//  At most one done bit per cycle. grant and done never high in the same cycle.
//  Counter widths: prescaler clog2(TICK_DIV) bits, remain_ms DW bits. No wrap below 0.
//  Asynchronous rstn mid-operation: immediate return to reset values; no done issued.
// STRUCTURE
//  delay_sched_defs.vh: state localparams (S_IDLE, S_RUN, S_DONE), clog2 function.
//  Sub-module rr_arbiter: combinational round-robin pick (eligible, pointer -> one-hot, index).
//  Top holds FSM, prescaler, remain counter, served mask.
// TESTING (TICK_DIV=4, NREQ=4, DW=16)
//  req[1]=1, ms=3 at T0 -> grant[1] T1..T13, done[1] at T14, remain_ms steps 3,2,1,0.
//  req[2]=1, ms=0 -> done[2] at T0+2. req held high afterwards -> no second grant until req drops.
//  req=4'b1111 together, all ms=1, ptr=0 -> done order 0,1,2,3. Re-request all -> order 0,1,2,3 again.
//  req[3] dropped mid-RUN (ms=5) -> grant low next cycle, no done[3], next pending served.
//  req[0] dropped in same cycle remain_ms hits 0 -> abort, no done[0].
//  rstn pulsed low mid-RUN -> all outputs 0 asynchronously; fresh req serviced normally afterwards.
//  Assertions: grant one-hot-or-zero; done one-hot-or-zero; never grant&done; busy==(state!=IDLE).

Source files
------------

// File: rtl/delay_sched_rr_pkg.sv
// Shared types and helpers for the round-robin millisecond delay scheduler.
package delay_sched_rr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for v<=1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Keeps derived vector widths at least one bit wide.
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/delay_sched_rr_arb.sv
// Combinational round-robin pick: first eligible requester at or above the
// pointer, wrapping around. Produces one-hot grant, its index and a valid flag.
module delay_sched_rr_arb
    import delay_sched_rr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    // Scan positions ptr, ptr+1, ... (mod NREQ); the first eligible one wins.
    always_comb begin
        logic w_found;
        int   w_pos;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && i_elig[j] && (j == w_pos)) begin
                    w_found  = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = IW'(j);
                end
            end
        end
        o_vld = w_found;
    end

endmodule

// File: rtl/delay_sched_rr.sv
// One shared millisecond delay engine (prescaler + down-counter) handed out to
// NREQ requesters in round-robin order. Each grant counts its latched delay and
// ends with a one-cycle done pulse, or is aborted when the requester drops req.
module delay_sched_rr
    import delay_sched_rr_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 16,
    parameter int TICK_DIV = 50000,
    localparam int IW      = max1(clog2(NREQ)),
    localparam int PW      = max1(clog2(TICK_DIV))
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_ms,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [IW-1:0]      cur_id,
    output logic [DW-1:0]      remain_ms
);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_cur_id, w_id_nxt;
    logic [NREQ-1:0] r_cur_oh, w_oh_nxt;
    logic [DW-1:0]   r_remain, w_rem_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [NREQ-1:0] r_served;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic            w_arb_vld;
    logic [IW-1:0]   w_ptr_adv;

    // Requesters already served stay masked until they drop req for a cycle.
    assign w_elig    = req & ~r_served;
    assign w_ptr_adv = (r_cur_id == IW'(NREQ - 1)) ? '0 : r_cur_id + 1'b1;

    delay_sched_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_vld  (w_arb_vld)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath next values; abort is tested before the zero check.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_cur_id;
        w_oh_nxt    = r_cur_oh;
        w_rem_nxt   = r_remain;
        w_pre_nxt   = r_pre;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = S_RUN;
                    w_id_nxt    = w_arb_idx;
                    w_oh_nxt    = w_arb_gnt;
                    w_rem_nxt   = req_ms[w_arb_idx*DW +: DW];
                    w_pre_nxt   = '0;
                end
            end
            S_RUN: begin
                if ((req & r_cur_oh) == '0) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                    w_ptr_nxt   = w_ptr_adv;
                end else if (r_remain == '0) begin
                    w_state_nxt = S_DONE;
                end else if (r_pre == PW'(TICK_DIV - 1)) begin
                    w_pre_nxt = '0;
                    w_rem_nxt = r_remain - 1'b1;
                end else begin
                    w_pre_nxt = r_pre + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = w_ptr_adv;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers; served mask sets on done, clears whenever req is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur_id <= '0;
            r_cur_oh <= '0;
            r_remain <= '0;
            r_pre    <= '0;
            r_ptr    <= '0;
            r_served <= '0;
        end else begin
            r_cur_id <= w_id_nxt;
            r_cur_oh <= w_oh_nxt;
            r_remain <= w_rem_nxt;
            r_pre    <= w_pre_nxt;
            r_ptr    <= w_ptr_nxt;
            r_served <= (r_served | done) & req;
        end
    end

    assign grant     = (r_state == S_RUN)  ? r_cur_oh : '0;
    assign done      = (r_state == S_DONE) ? r_cur_oh : '0;
    assign busy      = (r_state != S_IDLE);
    assign cur_id    = r_cur_id;
    assign remain_ms = r_remain;

endmodule
